ex_stage_ctrl: RTL and testbench

//  Parametrised execute stage: XLEN-wide ALU, branch/jump resolution, and redirect/flush FSM

---
 rtl/ex_pkg.sv | 36 +++
 rtl/ex_alu.sv | 40 ++++
 rtl/ex_stage_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_ex_stage_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared encodings for the execute stage (ALU ops, branch FUN3 codes, FSM states)
package ex_pkg;

    // ALU_CNT encodings; ALU_MSTD hands the operation to the external mul/div unit.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_B4    = 4'd10,
        ALU_PASSB = 4'd11,
        ALU_MSTD  = 4'd12,
        ALU_IDLE  = 4'd15
    } alu_op_e;

    // Conditional branch FUN3 codes; 3'd2 and 3'd3 are never taken.
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_BUSY = 2'd1,
        ST_SQUASH  = 2'd2
    } ex_state_e;

endpackage

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - combinational XLEN-wide ALU
// Ports: alu_cnt (op), a/b (operands), y (result).
// SUB = b - a, SLT/SLTU = b < a, shifts move b by the low $clog2(XLEN) bits of a.
module ex_alu
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      alu_cnt,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = a[SHW-1:0];

    always_comb begin
        y = '0;
        case (alu_cnt)
            ALU_ADD:   y = b + a;
            ALU_SUB:   y = b - a;
            ALU_SLL:   y = b << shamt;
            ALU_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(b) < $signed(a))};
            ALU_SLTU:  y = {{(XLEN-1){1'b0}}, (b < a)};
            ALU_XOR:   y = b ^ a;
            ALU_SRL:   y = b >> shamt;
            ALU_SRA:   y = $unsigned($signed(b) >>> shamt);
            ALU_OR:    y = b | a;
            ALU_AND:   y = b & a;
            ALU_B4:    y = b + XLEN'(4);
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage_ctrl.sv
// rtl/ex_stage_ctrl.sv - execute stage: ALU, branch/jump resolution, redirect/flush FSM, mul/div handshake
// Parameters: XLEN datapath width, FLUSH_O front-end flush length, FLUSH_I_LEN internal squash
//   length (named apart from the FLUSH_I port it drives; FLUSH_I_LEN >= FLUSH_O).
// Inputs: CLK, RST_N (async, active low), CACHE_READY (global advance), IN_VALID, ALU_CNT, FUN3,
//   A, B, COMP1, COMP2, JUMP, JUMPR, CBRANCH, JUMP_BUS1, JUMP_BUS2, PC_EX, PC_NEXT,
//   PRIV_JUMP, PRIV_JUMP_ADD, MD_READY, MD_RESULT.
// Outputs: MD_START, MD_ABORT, WB_VALID, WB_DATA, JUMP_FINAL, JUMP_ADDR, FLUSH, FLUSH_I,
//   PREDICTED, STALLED.
// Optional: EX_PERF_CNT_EN adds PERF_BRANCH, PERF_MISPRED, PERF_MD_STALL saturating counters.
module ex_stage_ctrl
    import ex_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int FLUSH_O     = 4,
    parameter int FLUSH_I_LEN = 6
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            CACHE_READY,
    input  logic            IN_VALID,
    input  logic [3:0]      ALU_CNT,
    input  logic [2:0]      FUN3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [XLEN-1:0] COMP1,
    input  logic [XLEN-1:0] COMP2,
    input  logic            JUMP,
    input  logic            JUMPR,
    input  logic            CBRANCH,
    input  logic [XLEN-1:0] JUMP_BUS1,
    input  logic [XLEN-1:0] JUMP_BUS2,
    input  logic [XLEN-1:0] PC_EX,
    input  logic [XLEN-1:0] PC_NEXT,
    input  logic            PRIV_JUMP,
    input  logic [XLEN-1:0] PRIV_JUMP_ADD,
    output logic            MD_START,
    output logic            MD_ABORT,
    input  logic            MD_READY,
    input  logic [XLEN-1:0] MD_RESULT,
    output logic            WB_VALID,
    output logic [XLEN-1:0] WB_DATA,
    output logic            JUMP_FINAL,
    output logic [XLEN-1:0] JUMP_ADDR,
    output logic            FLUSH,
    output logic            FLUSH_I,
    output logic            PREDICTED,
    output logic            STALLED
`ifdef EX_PERF_CNT_EN
   ,output logic [31:0]     PERF_BRANCH,
    output logic [31:0]     PERF_MISPRED,
    output logic [31:0]     PERF_MD_STALL
`endif
);

    localparam int CW = $clog2(FLUSH_I_LEN + 1);

    ex_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_o_q, cnt_o_d;
    logic [CW-1:0]   cnt_i_q, cnt_i_d;

    logic [XLEN-1:0] alu_y;
    logic            v;
    logic            cond;
    logic            taken;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            md_go;
    logic            wb_en;

    ex_alu #(.XLEN(XLEN)) u_alu (
        .alu_cnt (ALU_CNT),
        .a       (A),
        .b       (B),
        .y       (alu_y)
    );

    // Only RUN accepts new work: SQUASH drops it, and in MD_BUSY the held input is the
    // mul/div instruction already issued.
    assign v = IN_VALID & (state_q == ST_RUN);

    always_comb begin
        cond = 1'b0;
        case (FUN3)
            F3_BEQ:  cond = (COMP1 == COMP2);
            F3_BNE:  cond = (COMP1 != COMP2);
            F3_BLT:  cond = ($signed(COMP1) <  $signed(COMP2));
            F3_BGE:  cond = ($signed(COMP1) >= $signed(COMP2));
            F3_BLTU: cond = (COMP1 <  COMP2);
            F3_BGEU: cond = (COMP1 >= COMP2);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        taken = PRIV_JUMP | (CBRANCH ? cond : (JUMP | JUMPR));
        if (PRIV_JUMP)
            target = PRIV_JUMP_ADD;
        else if (taken)
            target = JUMP_BUS1 + JUMP_BUS2;
        else
            target = PC_EX + XLEN'(4);
        // Traps/xRET always redirect and are never squashed; ordinary instructions
        // redirect only when the fetched PC disagrees with the resolved one.
        redirect = PRIV_JUMP | (v & (PC_NEXT != target));
        md_go    = v & (ALU_CNT == ALU_MSTD) & ~redirect;
        wb_en    = v & ~PRIV_JUMP & (ALU_CNT != ALU_MSTD) & (ALU_CNT != ALU_IDLE);
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
            cnt_o_q <= '0;
            cnt_i_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_o_q <= cnt_o_d;
            cnt_i_q <= cnt_i_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_o_d = cnt_o_q;
        cnt_i_d = cnt_i_q;
        if (CACHE_READY) begin
            case (state_q)
                ST_RUN: begin
                    if (redirect) begin
                        state_d = ST_SQUASH;
                        cnt_o_d = CW'(FLUSH_O);
                        cnt_i_d = CW'(FLUSH_I_LEN);
                    end else if (md_go) begin
                        state_d = ST_MD_BUSY;
                    end
                end
                ST_MD_BUSY: begin
                    if (PRIV_JUMP) begin
                        state_d = ST_SQUASH;
                        cnt_o_d = CW'(FLUSH_O);
                        cnt_i_d = CW'(FLUSH_I_LEN);
                    end else if (MD_READY) begin
                        state_d = ST_RUN;
                    end
                end
                ST_SQUASH: begin
                    if (PRIV_JUMP) begin
                        cnt_o_d = CW'(FLUSH_O);
                        cnt_i_d = CW'(FLUSH_I_LEN);
                    end else begin
                        cnt_o_d = (cnt_o_q == '0) ? '0 : cnt_o_q - CW'(1);
                        if (cnt_i_q <= CW'(1)) begin
                            cnt_i_d = '0;
                            state_d = ST_RUN;
                        end else begin
                            cnt_i_d = cnt_i_q - CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_o_d = '0;
                    cnt_i_d = '0;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        FLUSH      = (cnt_o_q != '0);
        FLUSH_I    = (cnt_i_q != '0);
        MD_START   = (state_q == ST_RUN) & md_go & CACHE_READY;
        MD_ABORT   = (state_q == ST_MD_BUSY) & PRIV_JUMP & CACHE_READY;
        STALLED    = ((state_q == ST_RUN) & md_go) |
                     ((state_q == ST_MD_BUSY) & ~MD_READY & ~PRIV_JUMP);
        JUMP_FINAL = (v & taken) | PRIV_JUMP;
        JUMP_ADDR  = target;
        PREDICTED  = ~redirect;
    end

    // Result register: ALU result from RUN, mul/div result when MD_BUSY completes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WB_VALID <= 1'b0;
            WB_DATA  <= '0;
        end else if (CACHE_READY) begin
            case (state_q)
                ST_RUN: begin
                    WB_VALID <= wb_en;
                    WB_DATA  <= alu_y;
                end
                ST_MD_BUSY: begin
                    WB_VALID <= MD_READY & ~PRIV_JUMP;
                    WB_DATA  <= MD_RESULT;
                end
                default: begin
                    WB_VALID <= 1'b0;
                end
            endcase
        end
    end

`ifdef EX_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PERF_BRANCH   <= '0;
            PERF_MISPRED  <= '0;
            PERF_MD_STALL <= '0;
        end else if (CACHE_READY) begin
            if (v & CBRANCH & (PERF_BRANCH != '1))
                PERF_BRANCH <= PERF_BRANCH + 32'd1;
            if (redirect & (PERF_MISPRED != '1))
                PERF_MISPRED <= PERF_MISPRED + 32'd1;
            if ((state_q == ST_MD_BUSY) & (PERF_MD_STALL != '1))
                PERF_MD_STALL <= PERF_MD_STALL + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// tb/tb_ex_stage_ctrl.sv - directed-vector bench for ex_stage_ctrl (XLEN=32 and XLEN=64 instances)
module tb_ex_stage_ctrl;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cache_ready;
    logic        in_valid;
    logic [3:0]  alu_cnt;
    logic [2:0]  fun3;
    logic [31:0] a, b, comp1, comp2, bus1, bus2, pc_ex, pc_next, priv_add, md_result;
    logic        jump, jumpr, cbranch, priv_jump, md_ready;
    logic        md_start, md_abort, wb_valid, jump_final, flush, flush_i, predicted, stalled;
    logic [31:0] wb_data, jump_addr;

    logic        in_valid64;
    logic [3:0]  alu64;
    logic [63:0] a64, b64;
    logic        md_start64, md_abort64, wb_valid64, jump_final64, flush64, flush_i64, predicted64, stalled64;
    logic [63:0] wb_data64, jump_addr64;

`ifdef EX_PERF_CNT_EN
    logic [31:0] pb, pm, ps, pb64, pm64, ps64;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ex_stage_ctrl #(.XLEN(32), .FLUSH_O(4), .FLUSH_I_LEN(6)) u_dut (
        .CLK(clk), .RST_N(rst_n), .CACHE_READY(cache_ready), .IN_VALID(in_valid),
        .ALU_CNT(alu_cnt), .FUN3(fun3), .A(a), .B(b), .COMP1(comp1), .COMP2(comp2),
        .JUMP(jump), .JUMPR(jumpr), .CBRANCH(cbranch), .JUMP_BUS1(bus1), .JUMP_BUS2(bus2),
        .PC_EX(pc_ex), .PC_NEXT(pc_next), .PRIV_JUMP(priv_jump), .PRIV_JUMP_ADD(priv_add),
        .MD_START(md_start), .MD_ABORT(md_abort), .MD_READY(md_ready), .MD_RESULT(md_result),
        .WB_VALID(wb_valid), .WB_DATA(wb_data), .JUMP_FINAL(jump_final), .JUMP_ADDR(jump_addr),
        .FLUSH(flush), .FLUSH_I(flush_i), .PREDICTED(predicted), .STALLED(stalled)
`ifdef EX_PERF_CNT_EN
       ,.PERF_BRANCH(pb), .PERF_MISPRED(pm), .PERF_MD_STALL(ps)
`endif
    );

    ex_stage_ctrl #(.XLEN(64), .FLUSH_O(4), .FLUSH_I_LEN(6)) u_dut64 (
        .CLK(clk), .RST_N(rst_n), .CACHE_READY(cache_ready), .IN_VALID(in_valid64),
        .ALU_CNT(alu64), .FUN3(3'd0), .A(a64), .B(b64), .COMP1(64'd0), .COMP2(64'd0),
        .JUMP(1'b0), .JUMPR(1'b0), .CBRANCH(1'b0), .JUMP_BUS1(64'd0), .JUMP_BUS2(64'd0),
        .PC_EX(64'd0), .PC_NEXT(64'd4), .PRIV_JUMP(1'b0), .PRIV_JUMP_ADD(64'd0),
        .MD_START(md_start64), .MD_ABORT(md_abort64), .MD_READY(1'b0), .MD_RESULT(64'd0),
        .WB_VALID(wb_valid64), .WB_DATA(wb_data64), .JUMP_FINAL(jump_final64), .JUMP_ADDR(jump_addr64),
        .FLUSH(flush64), .FLUSH_I(flush_i64), .PREDICTED(predicted64), .STALLED(stalled64)
`ifdef EX_PERF_CNT_EN
       ,.PERF_BRANCH(pb64), .PERF_MISPRED(pm64), .PERF_MD_STALL(ps64)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; alu_cnt = ALU_IDLE; fun3 = 3'd0; a = '0; b = '0;
        comp1 = '0; comp2 = '0; jump = 1'b0; jumpr = 1'b0; cbranch = 1'b0;
        bus1 = '0; bus2 = '0; pc_ex = 32'h100; pc_next = 32'h104;
        priv_jump = 1'b0; priv_add = '0; md_ready = 1'b0; md_result = '0;
    endtask

    task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] exp);
        in_valid = 1'b1; alu_cnt = op; a = av; b = bv; jump = 1'b0; cbranch = 1'b0;
        pc_ex = 32'h200; pc_next = 32'h204;
        step();
        check_eq(tag, wb_data, exp);
    endtask

    // Combinational resolution only; caller holds CACHE_READY low so nothing commits.
    task automatic br_chk(input string tag, input logic [2:0] f3, input logic cb, input logic jr,
                          input logic [31:0] c1, input logic [31:0] c2,
                          input logic exp_taken, input logic [31:0] exp_addr);
        in_valid = 1'b1; alu_cnt = ALU_IDLE; fun3 = f3; cbranch = cb; jumpr = jr;
        comp1 = c1; comp2 = c2; bus1 = 32'h40; bus2 = 32'h40; pc_ex = 32'h100; pc_next = 32'h104;
        #1;
        check_eq({tag, "_taken"}, jump_final, exp_taken);
        check_eq({tag, "_addr"}, jump_addr, exp_addr);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: total=%0d", n_total);
        $fatal(1, "timeout");
    end

    initial begin
        int fo, fi, wb, st, starts;
        rst_n = 1'b0; cache_ready = 1'b1; idle();
        in_valid64 = 1'b0; alu64 = ALU_IDLE; a64 = '0; b64 = '0;
        #2;
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_wb_data", wb_data, 0);
        check_eq("rst_flush", flush, 0);
        check_eq("rst_flush_i", flush_i, 0);
        check_eq("rst_stalled", stalled, 0);
        check_eq("rst_predicted", predicted, 1);
        step(); rst_n = 1'b1; step();

        // reset while MD_BUSY: op dropped, no abort, no late write-back
        in_valid = 1'b1; alu_cnt = ALU_MSTD;
        #1; check_eq("t1_md_start", md_start, 1);
        step(); idle(); step();
        check_eq("t1_busy_stall", stalled, 1);
        #1; rst_n = 1'b0; #1;
        check_eq("t1_rst_stalled", stalled, 0);
        check_eq("t1_rst_abort", md_abort, 0);
        check_eq("t1_rst_predicted", predicted, 1);
        step(); rst_n = 1'b1; md_ready = 1'b1; md_result = 32'h1234;
        step(); md_ready = 1'b0;
        check_eq("t1_no_wb", wb_valid, 0);

        // ADD on predicted path, then ALU vectors
        in_valid = 1'b1; alu_cnt = ALU_ADD; a = 32'd3; b = 32'd5; pc_ex = 32'h200; pc_next = 32'h204;
        #1;
        check_eq("t3_predicted", predicted, 1);
        check_eq("t3_jump_final", jump_final, 0);
        check_eq("t3_jump_addr", jump_addr, 32'h204);
        step();
        check_eq("t3_wb_valid", wb_valid, 1);
        check_eq("t3_wb_data", wb_data, 32'd8);
        check_eq("t3_flush", flush, 0);
        run_alu("sub",      ALU_SUB,  32'd3,  32'd10,       32'd7);
        run_alu("sll",      ALU_SLL,  32'd4,  32'd1,        32'd16);
        run_alu("sll_mask", ALU_SLL,  32'd36, 32'd1,        32'd16);
        run_alu("slt",      ALU_SLT,  32'd1,  32'hFFFFFFFF, 32'd1);
        run_alu("sltu",     ALU_SLTU, 32'd1,  32'hFFFFFFFF, 32'd0);
        run_alu("sra4",     ALU_SRA,  32'd4,  32'h80000000, 32'hF8000000);
        run_alu("sra31",    ALU_SRA,  32'd31, 32'h80000000, 32'hFFFFFFFF);
        run_alu("srl4",     ALU_SRL,  32'd4,  32'h80000000, 32'h08000000);
        run_alu("xor",      ALU_XOR,  32'h0F, 32'hFF,       32'hF0);
        run_alu("b4_wrap",  ALU_B4,   32'd0,  32'hFFFFFFFE, 32'd2);
        run_alu("add_wrap", ALU_ADD,  32'd1,  32'hFFFFFFFF, 32'd0);
        idle(); step();

        // branch conditions with the stage frozen
        cache_ready = 1'b0;
        br_chk("blt",   F3_BLT,  1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 32'h80);
        br_chk("bltu",  F3_BLTU, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h104);
        br_chk("bge",   F3_BGE,  1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h104);
        br_chk("f3_2",  3'd2,    1'b1, 1'b0, 32'd7,        32'd7, 1'b0, 32'h104);
        br_chk("jalr",  3'd0,    1'b0, 1'b1, 32'd0,        32'd1, 1'b1, 32'h80);
        step(); idle(); cache_ready = 1'b1; #1;
        check_eq("frozen_no_flush", flush_i, 0);
        step();

        // BEQ mispredict: 4 cycles FLUSH, 6 cycles FLUSH_I, squashed ADDs
        in_valid = 1'b1; cbranch = 1'b1; fun3 = F3_BEQ; comp1 = 32'd5; comp2 = 32'd5;
        bus1 = 32'hF0; bus2 = 32'h10; pc_ex = 32'h100; pc_next = 32'h104; alu_cnt = ALU_IDLE;
        #1;
        check_eq("t2_jump_final", jump_final, 1);
        check_eq("t2_jump_addr", jump_addr, 32'h100);
        check_eq("t2_predicted", predicted, 0);
        step();
        cbranch = 1'b0; alu_cnt = ALU_ADD; a = 32'd1; b = 32'd1;
        check_eq("t2_branch_wb", wb_valid, 0);
        fo = 0; fi = 0; wb = 0;
        for (int k = 0; k < 10; k++) begin
            fo += int'(flush); fi += int'(flush_i);
            step();
            wb += int'(wb_valid);
        end
        check_eq("t2_flush_cycles", fo, 4);
        check_eq("t2_flush_i_cycles", fi, 6);
        check_eq("t2_wb_after_squash", wb, 4);
        idle(); step();

        // mul/div: 8 stall cycles, one write-back of 0xDEAD
        in_valid = 1'b1; alu_cnt = ALU_MSTD; md_result = 32'hDEAD;
        #1;
        check_eq("t4_md_start", md_start, 1);
        st = int'(stalled); starts = 0; wb = 0;
        step();
        for (int c = 1; c <= 8; c++) begin
            md_ready = (c == 8);
            #1;
            st += int'(stalled); starts += int'(md_start);
            step();
            wb += int'(wb_valid);
        end
        check_eq("t4_wb_data", wb_data, 32'hDEAD);
        idle(); step();
        wb += int'(wb_valid);
        check_eq("t4_stall_cycles", st, 8);
        check_eq("t4_extra_starts", starts, 0);
        check_eq("t4_wb_count", wb, 1);

        // PRIV_JUMP during MD_BUSY, then a second PRIV_JUMP restarts the squash
        in_valid = 1'b1; alu_cnt = ALU_MSTD;
        step(); idle();
        priv_jump = 1'b1; priv_add = 32'h80;
        #1;
        check_eq("t5_md_abort", md_abort, 1);
        check_eq("t5_jump_addr", jump_addr, 32'h80);
        check_eq("t5_jump_final", jump_final, 1);
        step(); priv_jump = 1'b0;
        check_eq("t5_flush", flush, 1);
        check_eq("t5_wb_valid", wb_valid, 0);
        step(); step();
        priv_jump = 1'b1; #1;
        check_eq("t5_no_abort_in_squash", md_abort, 0);
        step(); priv_jump = 1'b0;
        fo = 0; fi = 0;
        for (int k = 0; k < 10; k++) begin
            fo += int'(flush); fi += int'(flush_i);
            step();
        end
        check_eq("t5_restart_flush", fo, 4);
        check_eq("t5_restart_flush_i", fi, 6);

        // JAL redirect, then freeze mid-SQUASH
        in_valid = 1'b1; jump = 1'b1; alu_cnt = ALU_B4; b = 32'h100;
        bus1 = 32'h300; bus2 = 32'h0; pc_ex = 32'h100; pc_next = 32'h104;
        #1;
        check_eq("t6_jal_final", jump_final, 1);
        step(); idle();
        check_eq("t6_link", wb_data, 32'h104);
        step(); step();
        cache_ready = 1'b0;
        repeat (5) step();
        check_eq("t6_hold_flush", flush, 1);
        check_eq("t6_hold_flush_i", flush_i, 1);
        cache_ready = 1'b1;
        fo = 0; fi = 0;
        for (int k = 0; k < 8; k++) begin
            fo += int'(flush); fi += int'(flush_i);
            step();
        end
        check_eq("t6_rem_flush", fo, 2);
        check_eq("t6_rem_flush_i", fi, 4);

        // XLEN=64 arithmetic shift
        in_valid64 = 1'b1; alu64 = ALU_SRA; a64 = 64'd63; b64 = 64'h8000_0000_0000_0000;
        step();
        check_eq("x64_sra63_valid", wb_valid64, 1);
        check_eq("x64_sra63", wb_data64, 64'hFFFF_FFFF_FFFF_FFFF);
        a64 = 64'd1;
        step();
        check_eq("x64_sra1", wb_data64, 64'hC000_0000_0000_0000);
        in_valid64 = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
